id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the RISC-V core. Sits directly downstream of the register file.
- Captures the two register-file read operands plus decoded control and immediate each cycle.
- Applies write-back bypass to cover the same-cycle register-file write/read case.
- Detects load-use hazards, inserting a bubble and stalling decode.
- Supports EX hold and branch flush, and keeps saturating bubble/flush event counters.

Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, width of the bubble and flush event counters

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  PC of the decoding instruction
- id_rs1, id_rs2  in  5  source register indices (the same values drive the register file read_reg1/read_reg2)
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2
- id_rd  in  5  destination index
- id_imm  in  XLEN  sign-extended immediate
- id_alu_op  in  4  ALU operation code
- id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1  decoded controls
- rf_read_data1, rf_read_data2  in  XLEN  register file read outputs
- wb_reg_write  in  1  write-back enable (the same signal drives the register file reg_write)
- wb_write_reg  in  5  write-back index
- wb_write_data  in  XLEN  write-back data
- ex_hold  in  1  EX cannot accept a new instruction this cycle
- flush  in  1  taken branch/jump resolved in EX; kill the instruction entering EX
- id_stall  out  1  combinational; freeze the PC and the IF/ID register
- ex_valid  out  1  EX slot valid
- ex_pc, ex_op1, ex_op2, ex_imm  out  XLEN  registered PC, operands, immediate
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices, used by the EX forwarding unit
- ex_alu_op  out  4  registered ALU op
- ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1  registered controls
- bubble_count, flush_count  out  CNT_W  saturating event counters

Behaviour:
- Reset (synchronous, active-high, highest priority): every registered output and both counters go to 0, including ex_valid.
- Operand selection (combinational, ID side), shown for op1; op2 is identical with rs2:
  - If id_rs1 == 0, op1 = 0.
  - Else if wb_reg_write and wb_write_reg == id_rs1 and wb_write_reg != 0, op1 = wb_write_data.
  - Else op1 = rf_read_data1.
- Load-use hazard (combinational): lu = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- id_stall = ex_hold | (lu & ~flush). flush overrides lu because the ID instruction is also being killed upstream.
- Per-cycle update priority, evaluated at posedge clk:
  1. reset: clear everything.
  2. flush: ex_valid=0; ex_mem_read, ex_mem_write, ex_reg_write=0; flush_count += 1 if a valid instruction occupied ID or EX. Flush wins over ex_hold.
  3. ex_hold: all ex_* registers keep their value; counters unchanged.
  4. lu: insert a bubble (ex_valid=0, all write/memory controls 0, datapath fields don't-care but driven to 0); bubble_count += 1.
  5. otherwise: capture every id_* field and the selected operands; ex_valid = id_valid; controls are ANDed with id_valid so a non-valid slot never writes.
- Latency: one cycle from ID to EX outputs. A load-use hazard costs exactly one bubble, because the next cycle ex_mem_read is 0 and lu deasserts.
- Counters saturate at 2^CNT_W-1; they do not wrap.
- Held contents are frozen while ex_hold is asserted. A write-back to a held instruction's source during hold is resolved by EX forwarding, not here.
- Reset asserted mid-hold or mid-stall clears state in that cycle; the first post-reset cycle captures normally.

Test Plan:
- Reset with all inputs random -> next cycle ex_valid=0, ex_reg_write=0, ex_op1=0, bubble_count=0, flush_count=0.
- id_rs1=5, rf_read_data1=0x11, wb_reg_write=1, wb_write_reg=5, wb_write_data=0xDEAD_BEEF -> ex_op1=0xDEADBEEF after 1 cycle. Same stimulus with wb_write_reg=0 -> ex_op1=0x11.
- Load to x7 in EX (ex_mem_read=1, ex_rd=7), ID has add with id_uses_rs2=1, id_rs2=7 -> id_stall=1 for exactly 1 cycle; EX receives a bubble (ex_valid=0, ex_reg_write=0); the add enters EX the following cycle; bubble_count=1.
- Same load-use case with id_uses_rs2=0, or with ex_rd=0 -> id_stall=0, no bubble.
- ex_hold=1 for 3 cycles with changing id_* inputs -> ex_* outputs unchanged and id_stall=1 throughout. flush asserted together with ex_hold -> ex_valid=0 next cycle, flush_count increments.
- Force 2^CNT_W+3 load-use events (CNT_W=4 build) -> bubble_count holds at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: write-back bypass on the register-file read operands,
// load-use bubble insertion, EX hold, branch flush and saturating event counters.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [3:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic [XLEN-1:0]  rf_read_data1,
  input  logic [XLEN-1:0]  rf_read_data2,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_write_reg,
  input  logic [XLEN-1:0]  wb_write_data,
  input  logic             ex_hold,
  input  logic             flush,
  output logic             id_stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_op1,
  output logic [XLEN-1:0]  ex_op2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0] op1_sel;
  logic [XLEN-1:0] op2_sel;
  logic            load_use;

  // x0 reads as zero; a same-cycle write-back wins over the stale register-file read.
  always_comb begin
    op1_sel = rf_read_data1;
    op2_sel = rf_read_data2;
    if (id_rs1 == 5'd0)
      op1_sel = '0;
    else if (wb_reg_write && (wb_write_reg == id_rs1))
      op1_sel = wb_write_data;
    if (id_rs2 == 5'd0)
      op2_sel = '0;
    else if (wb_reg_write && (wb_write_reg == id_rs2))
      op2_sel = wb_write_data;
  end

  always_comb begin
    load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    id_stall = ex_hold || (load_use && !flush);
  end

  // Priority: reset > flush > hold > load-use bubble > normal capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_op1        <= '0;
      ex_op2        <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_alu_op     <= '0;
      ex_alu_src    <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      bubble_count  <= '0;
      flush_count   <= '0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_reg_write <= 1'b0;
      if ((id_valid || ex_valid) && (flush_count != CNT_MAX))
        flush_count <= flush_count + CNT_W'(1);
    end else if (ex_hold) begin
      ex_valid <= ex_valid;
    end else if (load_use) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_op1        <= '0;
      ex_op2        <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_alu_op     <= '0;
      ex_alu_src    <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      if (bubble_count != CNT_MAX)
        bubble_count <= bubble_count + CNT_W'(1);
    end else begin
      // Controls gated by id_valid so an empty decode slot can never write.
      ex_valid      <= id_valid;
      ex_pc         <= id_pc;
      ex_op1        <= op1_sel;
      ex_op2        <= op2_sel;
      ex_imm        <= id_imm;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_alu_op     <= id_alu_op;
      ex_alu_src    <= id_alu_src;
      ex_mem_read   <= id_mem_read && id_valid;
      ex_mem_write  <= id_mem_write && id_valid;
      ex_reg_write  <= id_reg_write && id_valid;
      ex_mem_to_reg <= id_mem_to_reg && id_valid;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (CNT_W=4 build); expected EX contents are queued
// when stimulus is applied and compared one cycle later.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic [31:0] id_imm;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        ex_hold, flush;
  logic        id_stall, ex_valid;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [3:0]  bubble_count, flush_count;

  id_ex_stage #(.XLEN(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_imm(id_imm), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .id_mem_to_reg(id_mem_to_reg), .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .ex_hold(ex_hold), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .bubble_count(bubble_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, rw, mr, full;
    logic [31:0] pc, op1, op2;
    logic [4:0]  rd;
    logic [3:0]  bub, fl;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   bub_e = 0;
  int   fl_e = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic rw, input logic mr, input logic full,
                              input logic [31:0] pc, input logic [31:0] op1,
                              input logic [31:0] op2, input logic [4:0] rd);
    exp_t e;
    e.valid = v; e.rw = rw; e.mr = mr; e.full = full;
    e.pc = pc; e.op1 = op1; e.op2 = op2; e.rd = rd;
    e.bub = 4'(bub_e); e.fl = 4'(fl_e);
    return e;
  endfunction

  // Check the combinational stall, queue the expectation, then compare after the edge.
  task automatic step(input exp_t e, input logic chk_st, input logic st);
    exp_t g;
    #1;
    if (chk_st) chk("id_stall", 32'(id_stall), 32'(st));
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    chk("ex_valid", 32'(ex_valid), 32'(g.valid));
    chk("ex_reg_write", 32'(ex_reg_write), 32'(g.rw));
    chk("ex_mem_read", 32'(ex_mem_read), 32'(g.mr));
    chk("bubble_count", 32'(bubble_count), 32'(g.bub));
    chk("flush_count", 32'(flush_count), 32'(g.fl));
    if (g.full) begin
      chk("ex_pc", ex_pc, g.pc);
      chk("ex_op1", ex_op1, g.op1);
      chk("ex_op2", ex_op2, g.op2);
      chk("ex_rd", 32'(ex_rd), 32'(g.rd));
    end
  endtask

  task automatic idle();
    reset = 1'b0; id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_imm = '0; id_alu_op = '0;
    id_alu_src = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_reg_write = 1'b0;
    id_mem_to_reg = 1'b0; rf_read_data1 = '0; rf_read_data2 = '0; wb_reg_write = 1'b0;
    wb_write_reg = '0; wb_write_data = '0; ex_hold = 1'b0; flush = 1'b0;
  endtask

  task automatic instr(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic [31:0] d1, input logic [31:0] d2);
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_mem_to_reg = mr;
    rf_read_data1 = d1; rf_read_data2 = d2; wb_reg_write = 1'b0; id_imm = 32'h4; id_alu_op = 4'h2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every input random.
    reset = 1'b1; id_valid = 1'($urandom); id_pc = $urandom; id_rs1 = 5'($urandom);
    id_rs2 = 5'($urandom); id_rd = 5'($urandom); id_uses_rs1 = 1'($urandom);
    id_uses_rs2 = 1'($urandom); id_imm = $urandom; id_alu_op = 4'($urandom);
    id_alu_src = 1'($urandom); id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
    id_reg_write = 1'($urandom); id_mem_to_reg = 1'($urandom); rf_read_data1 = $urandom;
    rf_read_data2 = $urandom; wb_reg_write = 1'($urandom); wb_write_reg = 5'($urandom);
    wb_write_data = $urandom; ex_hold = 1'($urandom); flush = 1'($urandom);
    step(mk(0, 0, 0, 1, 0, 0, 0, 0), 1'b0, 1'b0);

    // Write-back bypass, bypass suppressed for x0 write, x0 source.
    idle();
    instr(32'h100, 5'd5, 1, 5'd6, 1, 5'd3, 1, 0, 32'h11, 32'h22);
    wb_reg_write = 1'b1; wb_write_reg = 5'd5; wb_write_data = 32'hDEAD_BEEF;
    step(mk(1, 1, 0, 1, 32'h100, 32'hDEAD_BEEF, 32'h22, 5'd3), 1'b1, 1'b0);
    instr(32'h104, 5'd5, 1, 5'd6, 1, 5'd3, 1, 0, 32'h11, 32'h22);
    wb_reg_write = 1'b1; wb_write_reg = 5'd0; wb_write_data = 32'hDEAD_BEEF;
    step(mk(1, 1, 0, 1, 32'h104, 32'h11, 32'h22, 5'd3), 1'b1, 1'b0);
    instr(32'h108, 5'd0, 1, 5'd6, 1, 5'd3, 1, 0, 32'h55, 32'h66);
    wb_reg_write = 1'b1; wb_write_reg = 5'd6; wb_write_data = 32'hCAFE_F00D;
    step(mk(1, 1, 0, 1, 32'h108, 32'h0, 32'hCAFE_F00D, 5'd3), 1'b1, 1'b0);

    // Load-use on rs2: one stall cycle, one bubble, then the add enters EX.
    instr(32'h10C, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 32'h1000, 32'h99);
    step(mk(1, 1, 1, 1, 32'h10C, 32'h1000, 32'h0, 5'd7), 1'b1, 1'b0);
    instr(32'h110, 5'd1, 1, 5'd7, 1, 5'd8, 1, 0, 32'h5, 32'h77);
    bub_e = 1;
    step(mk(0, 0, 0, 1, 0, 0, 0, 0), 1'b1, 1'b1);
    step(mk(1, 1, 0, 1, 32'h110, 32'h5, 32'h77, 5'd8), 1'b1, 1'b0);

    // Same dependence but rs2 not used: no stall.
    instr(32'h114, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 32'h1000, 32'h0);
    step(mk(1, 1, 1, 1, 32'h114, 32'h1000, 32'h0, 5'd7), 1'b1, 1'b0);
    instr(32'h118, 5'd1, 1, 5'd7, 0, 5'd8, 1, 0, 32'h5, 32'h77);
    step(mk(1, 1, 0, 1, 32'h118, 32'h5, 32'h77, 5'd8), 1'b1, 1'b0);

    // Load to x0 followed by an x0 reader: no stall.
    instr(32'h11C, 5'd2, 1, 5'd0, 0, 5'd0, 0, 1, 32'h1000, 32'h0);
    step(mk(1, 0, 1, 1, 32'h11C, 32'h1000, 32'h0, 5'd0), 1'b1, 1'b0);
    instr(32'h120, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0, 32'h5, 32'h77);
    step(mk(1, 1, 0, 1, 32'h120, 32'h0, 32'h0, 5'd8), 1'b1, 1'b0);

    // Capture A, then hold for three cycles with changing decode inputs.
    instr(32'h200, 5'd3, 1, 5'd4, 1, 5'd9, 1, 0, 32'hA1, 32'hA2);
    step(mk(1, 1, 0, 1, 32'h200, 32'hA1, 32'hA2, 5'd9), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      instr(32'h300 + 32'(i), 5'(i + 1), 1, 5'(i + 9), 1, 5'(i + 2), 1, 1, $urandom, $urandom);
      ex_hold = 1'b1;
      step(mk(1, 1, 0, 1, 32'h200, 32'hA1, 32'hA2, 5'd9), 1'b1, 1'b1);
    end

    // Flush together with hold kills EX and counts.
    flush = 1'b1;
    fl_e = 1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);

    // Flush overrides a load-use hazard; a flush with no valid instruction is not counted.
    idle();
    instr(32'h400, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 32'h1000, 32'h0);
    step(mk(1, 1, 1, 1, 32'h400, 32'h1000, 32'h0, 5'd7), 1'b1, 1'b0);
    instr(32'h404, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0, 32'h5, 32'h6);
    flush = 1'b1;
    fl_e = 2;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    idle();
    flush = 1'b1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);

    // 2^4+3 load-use events: bubble counter saturates at 15.
    for (int i = 0; i < 19; i++) begin
      idle();
      instr(32'h500, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 32'h1000, 32'h0);
      step(mk(1, 1, 1, 1, 32'h500, 32'h1000, 32'h0, 5'd7), 1'b1, 1'b0);
      instr(32'h504, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0, 32'h5, 32'h6);
      bub_e = (bub_e < 15) ? bub_e + 1 : 15;
      step(mk(0, 0, 0, 1, 0, 0, 0, 0), 1'b1, 1'b1);
      step(mk(1, 1, 0, 1, 32'h504, 32'h5, 32'h6, 5'd8), 1'b1, 1'b0);
    end
    chk("bubble_saturated", 32'(bubble_count), 32'd15);

    // Reset during hold clears everything; the next cycle captures normally.
    instr(32'h600, 5'd3, 1, 5'd4, 1, 5'd10, 1, 0, 32'hB1, 32'hB2);
    ex_hold = 1'b1;
    reset = 1'b1;
    bub_e = 0;
    fl_e = 0;
    step(mk(0, 0, 0, 1, 0, 0, 0, 0), 1'b1, 1'b1);
    reset = 1'b0;
    ex_hold = 1'b0;
    step(mk(1, 1, 0, 1, 32'h600, 32'hB1, 32'hB2, 5'd10), 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
